// File: rtl/magdetect_pkg.sv
// magdetect_pkg: shared state encoding, default parameter values and the
// threshold compare used by the Goertzel block scheduler.
package magdetect_pkg;

    localparam int          DEF_BLOCK_LEN      = 512;
    localparam int          DEF_ARM_CYCLES     = 8;
    localparam int          DEF_TIMEOUT_CYCLES = 4096;
    localparam logic [15:0] DEF_THRESH         = 16'h0400;
    localparam int          DEF_HYST_COUNT     = 3;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM         = 3'd1,
        STREAM      = 3'd2,
        WAIT_RESULT = 3'd3,
        REPORT      = 3'd4,
        RECOVER     = 3'd5
    } state_t;

    // Raw detect word: bit0 from tone 0, bit1 from tone 1, unsigned compares.
    function automatic logic [1:0] raw_detect(input logic [15:0] g0,
                                              input logic [15:0] g1,
                                              input logic [15:0] thr);
        return {(g1 >= thr), (g0 >= thr)};
    endfunction

endpackage

// File: rtl/magdetect_scheduler_rise_detect.sv
// rise_detect: registered rising-edge detector. The previous input level is
// held in a flop so a long strobe yields a single-cycle rise indication.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    // Remember last cycle's level of the strobe.
    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/magdetect_scheduler.sv
// magdetect_scheduler: arms a Goertzel core, forwards BLOCK_LEN ADC samples
// per block, collects the two magnitudes and reports a 2-bit tone detect.
// Build macro MAGDETECT_HYST_EN adds per-bit detect hysteresis (HYST_COUNT).
module magdetect_scheduler
    import magdetect_pkg::*;
#(
    parameter int          BLOCK_LEN      = DEF_BLOCK_LEN,
    parameter int          ARM_CYCLES     = DEF_ARM_CYCLES,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [15:0] THRESH         = DEF_THRESH,
    parameter int          HYST_COUNT     = DEF_HYST_COUNT
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    input  logic        adc_sample_valid,
    input  logic [7:0]  adc_sample,
    output logic        dsp_ce,
    output logic        dsp_data_rdy,
    output logic [7:0]  dsp_data,
    input  logic        dsp_g_ready,
    input  logic [15:0] dsp_g0,
    input  logic [15:0] dsp_g1,
    output logic [15:0] g0_mag,
    output logic [15:0] g1_mag,
    output logic        result_valid,
    output logic [1:0]  detect,
    output logic [15:0] block_count,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int SW = $clog2(BLOCK_LEN + 1);
    localparam int AW = $clog2(ARM_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(BLOCK_LEN - 1);
    localparam logic [AW-1:0] ARM_LAST    = AW'(ARM_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    if (BLOCK_LEN < 1 || ARM_CYCLES < 1 || TIMEOUT_CYCLES < 1 || HYST_COUNT < 1) begin : g_bad_cfg
        $error("magdetect_scheduler: counts must all be at least 1");
    end

    state_t         state, next_state;
    logic [SW-1:0]  sample_cnt;
    logic [AW-1:0]  arm_cnt;
    logic [TW-1:0]  to_cnt;
    logic           rise;
    logic [1:0]     raw_det;

    rise_detect u_rise (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .din  (adc_sample_valid),
        .rise (rise)
    );

    assign raw_det      = raw_detect(g0_mag, g1_mag, THRESH);
    assign result_valid = (state == REPORT);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state and core clock enable; dropping enable aborts everywhere but REPORT.
    always_comb begin
        next_state = state;
        dsp_ce     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = ARM;
            end
            ARM: begin
                dsp_ce = 1'b1;
                if (!enable)                next_state = IDLE;
                else if (arm_cnt == ARM_LAST) next_state = STREAM;
            end
            STREAM: begin
                dsp_ce = 1'b1;
                if (!enable)                            next_state = IDLE;
                else if (rise && sample_cnt == SAMPLE_LAST) next_state = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                dsp_ce = 1'b1;
                // A result arriving on the timeout cycle still counts.
                if (!enable)              next_state = IDLE;
                else if (dsp_g_ready)     next_state = REPORT;
                else if (to_cnt == TO_LAST) next_state = RECOVER;
            end
            REPORT: begin
                // Core stays clocked; the next block streams without re-arming.
                dsp_ce     = 1'b1;
                next_state = enable ? STREAM : IDLE;
            end
            RECOVER: begin
                next_state = enable ? ARM : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters, sample forwarding, result capture and sticky error flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            arm_cnt      <= '0;
            sample_cnt   <= '0;
            to_cnt       <= '0;
            dsp_data_rdy <= 1'b0;
            dsp_data     <= '0;
            g0_mag       <= '0;
            g1_mag       <= '0;
            block_count  <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            dsp_data_rdy <= 1'b0;
            arm_cnt      <= (state == ARM) ? arm_cnt + 1'b1 : '0;
            to_cnt       <= (state == WAIT_RESULT) ? to_cnt + 1'b1 : '0;

            if (state == STREAM && enable && rise) begin
                dsp_data_rdy <= 1'b1;
                dsp_data     <= adc_sample;
                sample_cnt   <= (sample_cnt == SAMPLE_LAST) ? '0 : sample_cnt + 1'b1;
            end else if (state == IDLE || state == ARM || state == RECOVER) begin
                sample_cnt <= '0;
            end

            if (state == WAIT_RESULT && next_state == REPORT) begin
                g0_mag <= dsp_g0;
                g1_mag <= dsp_g1;
            end

            if (state == REPORT) block_count <= block_count + 16'd1;

            if (state == IDLE && next_state == ARM) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (state == WAIT_RESULT && rise)           overrun     <= 1'b1;
                if (state == WAIT_RESULT && next_state == RECOVER) timeout_err <= 1'b1;
            end
        end
    end

`ifdef MAGDETECT_HYST_EN
    localparam int HW = $clog2(HYST_COUNT + 1);
    localparam logic [HW-1:0] HYST_LAST = HW'(HYST_COUNT - 1);

    logic [1:0][HW-1:0] hyst_cnt;

    // Each detect bit flips only after HYST_COUNT consecutive disagreeing reports.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            detect   <= '0;
            hyst_cnt <= '0;
        end else if (state == REPORT) begin
            for (int b = 0; b < 2; b++) begin
                if (raw_det[b] == detect[b]) begin
                    hyst_cnt[b] <= '0;
                end else if (hyst_cnt[b] == HYST_LAST) begin
                    detect[b]   <= raw_det[b];
                    hyst_cnt[b] <= '0;
                end else begin
                    hyst_cnt[b] <= hyst_cnt[b] + 1'b1;
                end
            end
        end
    end
`else
    // Detect follows the raw compare at every report.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)              detect <= '0;
        else if (state == REPORT) detect <= raw_det;
    end
`endif

endmodule

// File: tb/tb_magdetect_scheduler.sv
// tb_magdetect_scheduler: directed self-checking bench for magdetect_scheduler.
// Clock is 2 MHz so one 2 us strobe period is four clock cycles.
`timescale 1ns/1ps
module tb_magdetect_scheduler;

    localparam int BLK = 512;

`ifdef MAGDETECT_HYST_EN
    localparam logic [1:0] EXP_DET_NORMAL = 2'b00;
    localparam logic [1:0] EXP_DET_LONG   = 2'b00;
    localparam logic [2:0] EXP_HYST_BIT0  = 3'b100;
`else
    localparam logic [1:0] EXP_DET_NORMAL = 2'b01;
    localparam logic [1:0] EXP_DET_LONG   = 2'b10;
    localparam logic [2:0] EXP_HYST_BIT0  = 3'b111;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst, enable, adc_sample_valid, dsp_g_ready;
    logic [7:0]  adc_sample;
    logic [15:0] dsp_g0, dsp_g1;
    logic        dsp_ce, dsp_data_rdy, result_valid, overrun, timeout_err;
    logic [7:0]  dsp_data;
    logic [15:0] g0_mag, g1_mag, block_count;
    logic [1:0]  detect;

    int         n_vec = 0, n_bad = 0;
    int         rdy_cnt = 0, rv_cnt = 0, exp_bc = 0;
    logic [7:0] last_data = 8'h00;

    magdetect_scheduler dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
        .adc_sample_valid(adc_sample_valid), .adc_sample(adc_sample),
        .dsp_ce(dsp_ce), .dsp_data_rdy(dsp_data_rdy), .dsp_data(dsp_data),
        .dsp_g_ready(dsp_g_ready), .dsp_g0(dsp_g0), .dsp_g1(dsp_g1),
        .g0_mag(g0_mag), .g1_mag(g1_mag), .result_valid(result_valid),
        .detect(detect), .block_count(block_count),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #250 sys_clk = ~sys_clk;

    // Pulse monitor, sampled just after each rising edge.
    always begin
        @(posedge sys_clk);
        #1;
        if (dsp_data_rdy === 1'b1) begin
            rdy_cnt   = rdy_cnt + 1;
            last_data = dsp_data;
        end
        if (result_valid === 1'b1) rv_cnt = rv_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic strobe(input int hi, input int lo, input logic [7:0] d);
        adc_sample_valid = 1'b1;
        adc_sample       = d;
        tick(hi);
        adc_sample_valid = 1'b0;
        tick(lo);
    endtask

    task automatic run_block(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) strobe(hi, lo, 8'(i * 3 + 1));
    endtask

    // Leaves the bench at the negedge inside the REPORT cycle.
    task automatic give_result(input int gap, input logic [15:0] g0, input logic [15:0] g1);
        tick(gap);
        dsp_g_ready = 1'b1;
        dsp_g0      = g0;
        dsp_g1      = g1;
        tick(1);
        dsp_g_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        sys_rst = 1'b1; enable = 1'b0; adc_sample_valid = 1'b0; adc_sample = 8'h00;
        dsp_g_ready = 1'b0; dsp_g0 = 16'h0000; dsp_g1 = 16'h0000;
        tick(3);
        outs = {dsp_ce, dsp_data_rdy, dsp_data, g0_mag, g1_mag, result_valid, detect,
                block_count, overrun, timeout_err};
        n_vec++;
        if (outs !== 64'h0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        sys_rst = 1'b0;
        tick(4);
        n_vec++;
        if (dsp_ce !== 1'b0) begin
            n_bad++; $display("FAIL idle_hold_ce: got %b want 0", dsp_ce);
        end
    endtask

    task automatic test_normal();
        int r0, v0;
        r0 = rdy_cnt;
        enable = 1'b1;
        tick(1);
        n_vec++;
        if (dsp_ce !== 1'b1) begin
            n_bad++; $display("FAIL arm_ce: got %b want 1", dsp_ce);
        end
        strobe(1, 3, 8'hAA);
        tick(6);
        n_vec++;
        if (rdy_cnt !== r0) begin
            n_bad++; $display("FAIL arm_discard: got %0d pulses want 0", rdy_cnt - r0);
        end
        run_block(BLK, 1, 3);
        n_vec++;
        if (rdy_cnt - r0 !== BLK) begin
            n_bad++; $display("FAIL normal_pulses: got %0d want %0d", rdy_cnt - r0, BLK);
        end
        n_vec++;
        if (last_data !== 8'((BLK - 1) * 3 + 1)) begin
            n_bad++; $display("FAIL normal_last_data: got %h want %h", last_data, 8'((BLK - 1) * 3 + 1));
        end
        n_vec++;
        if ({dsp_ce, result_valid} !== 2'b10) begin
            n_bad++; $display("FAIL wait_state: got ce/rv %b want 10", {dsp_ce, result_valid});
        end
        v0 = rv_cnt;
        give_result(96, 16'h0500, 16'h0100);
        n_vec++;
        if (result_valid !== 1'b1) begin
            n_bad++; $display("FAIL normal_rv: got %b want 1", result_valid);
        end
        n_vec++;
        if ({g0_mag, g1_mag} !== {16'h0500, 16'h0100}) begin
            n_bad++; $display("FAIL normal_mags: got %h/%h want 0500/0100", g0_mag, g1_mag);
        end
        tick(1);
        exp_bc++;
        n_vec++;
        if (rv_cnt - v0 !== 1) begin
            n_bad++; $display("FAIL normal_rv_once: got %0d cycles want 1", rv_cnt - v0);
        end
        n_vec++;
        if (detect !== EXP_DET_NORMAL) begin
            n_bad++; $display("FAIL normal_detect: got %b want %b", detect, EXP_DET_NORMAL);
        end
        n_vec++;
        if (block_count !== 16'(exp_bc)) begin
            n_bad++; $display("FAIL normal_bc: got %0d want %0d", block_count, exp_bc);
        end
        n_vec++;
        if (dsp_ce !== 1'b1) begin
            n_bad++; $display("FAIL report_no_rearm: got %b want 1", dsp_ce);
        end
    endtask

    task automatic test_long_strobes();
        int r0;
        r0 = rdy_cnt;
        run_block(BLK, 3, 1);
        n_vec++;
        if (rdy_cnt - r0 !== BLK) begin
            n_bad++; $display("FAIL long_pulses: got %0d want %0d", rdy_cnt - r0, BLK);
        end
        give_result(10, 16'h03FF, 16'h0400);
        n_vec++;
        if (result_valid !== 1'b1) begin
            n_bad++; $display("FAIL long_rv: got %b want 1", result_valid);
        end
        tick(1);
        exp_bc++;
        n_vec++;
        if (detect !== EXP_DET_LONG) begin
            n_bad++; $display("FAIL long_detect_thresh_edge: got %b want %b", detect, EXP_DET_LONG);
        end
        n_vec++;
        if (block_count !== 16'(exp_bc)) begin
            n_bad++; $display("FAIL long_bc: got %0d want %0d", block_count, exp_bc);
        end
    endtask

    task automatic test_hysteresis();
        logic [2:0] exp0;
        exp0 = EXP_HYST_BIT0;
        for (int b = 0; b < 3; b++) begin
            run_block(BLK, 1, 3);
            give_result(20, 16'h0500, 16'h0000);
            tick(1);
            exp_bc++;
            n_vec++;
            if (detect[0] !== exp0[b]) begin
                n_bad++; $display("FAIL hyst_block%0d_bit0: got %b want %b", b + 1, detect[0], exp0[b]);
            end
            n_vec++;
            if (block_count !== 16'(exp_bc)) begin
                n_bad++; $display("FAIL hyst_block%0d_bc: got %0d want %0d", b + 1, block_count, exp_bc);
            end
        end
    endtask

    task automatic test_timeout();
        int v0;
        // Result arrives on exactly the cycle the timeout would fire.
        run_block(BLK, 1, 3);
        tick(4092);
        dsp_g_ready = 1'b1; dsp_g0 = 16'h0000; dsp_g1 = 16'h0000;
        tick(1);
        dsp_g_ready = 1'b0;
        n_vec++;
        if ({result_valid, timeout_err, dsp_ce} !== 3'b101) begin
            n_bad++; $display("FAIL ready_beats_timeout: got rv/te/ce %b want 101",
                              {result_valid, timeout_err, dsp_ce});
        end
        tick(1);
        exp_bc++;
        v0 = rv_cnt;
        run_block(BLK, 1, 3);
        tick(4092);
        n_vec++;
        if ({dsp_ce, timeout_err} !== 2'b10) begin
            n_bad++; $display("FAIL timeout_early: got ce/te %b want 10", {dsp_ce, timeout_err});
        end
        tick(1);
        n_vec++;
        if ({dsp_ce, timeout_err} !== 2'b01) begin
            n_bad++; $display("FAIL timeout_recover: got ce/te %b want 01", {dsp_ce, timeout_err});
        end
        tick(1);
        n_vec++;
        if ({dsp_ce, timeout_err} !== 2'b11) begin
            n_bad++; $display("FAIL timeout_rearm_sticky: got ce/te %b want 11", {dsp_ce, timeout_err});
        end
        n_vec++;
        if (rv_cnt !== v0 || block_count !== 16'(exp_bc)) begin
            n_bad++; $display("FAIL timeout_no_report: got rv %0d bc %0d want 0 / %0d",
                              rv_cnt - v0, block_count, exp_bc);
        end
        tick(10);
    endtask

    task automatic test_overrun_abort();
        int r0, v0;
        r0 = rdy_cnt;
        run_block(BLK, 1, 3);
        n_vec++;
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL overrun_pre: got %b want 0", overrun);
        end
        strobe(1, 3, 8'h55);
        n_vec++;
        if (rdy_cnt - r0 !== BLK) begin
            n_bad++; $display("FAIL overrun_no_fwd: got %0d pulses want %0d", rdy_cnt - r0, BLK);
        end
        n_vec++;
        if (overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        give_result(5, 16'h1234, 16'h0000);
        tick(1);
        exp_bc++;
        r0 = rdy_cnt;
        v0 = rv_cnt;
        run_block(200, 1, 3);
        enable = 1'b0;
        tick(1);
        n_vec++;
        if (dsp_ce !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle_ce: got %b want 0", dsp_ce);
        end
        tick(20);
        n_vec++;
        if (rdy_cnt - r0 !== 200 || rv_cnt !== v0 || block_count !== 16'(exp_bc)) begin
            n_bad++; $display("FAIL abort_no_result: got pulses %0d rv %0d bc %0d want 200/0/%0d",
                              rdy_cnt - r0, rv_cnt - v0, block_count, exp_bc);
        end
        n_vec++;
        if ({overrun, timeout_err} !== 2'b11) begin
            n_bad++; $display("FAIL flags_sticky_idle: got %b want 11", {overrun, timeout_err});
        end
        enable = 1'b1;
        tick(1);
        n_vec++;
        if ({dsp_ce, overrun, timeout_err} !== 3'b100) begin
            n_bad++; $display("FAIL arm_clears_flags: got ce/ov/te %b want 100",
                              {dsp_ce, overrun, timeout_err});
        end
        tick(10);
    endtask

    task automatic test_reset_mid_stream();
        int r0;
        logic [63:0] outs;
        r0 = rdy_cnt;
        run_block(299, 1, 3);
        // Sample 300 and reset land on the same edge.
        adc_sample_valid = 1'b1;
        adc_sample       = 8'h77;
        sys_rst          = 1'b1;
        tick(1);
        outs = {dsp_ce, dsp_data_rdy, dsp_data, g0_mag, g1_mag, result_valid, detect,
                block_count, overrun, timeout_err};
        n_vec++;
        if (outs !== 64'h0) begin
            n_bad++; $display("FAIL midblock_reset_outputs: got %h want 0", outs);
        end
        n_vec++;
        if (rdy_cnt - r0 !== 299) begin
            n_bad++; $display("FAIL midblock_reset_pulses: got %0d want 299", rdy_cnt - r0);
        end
        sys_rst          = 1'b0;
        adc_sample_valid = 1'b0;
        tick(11);
        r0 = rdy_cnt;
        run_block(BLK, 1, 3);
        n_vec++;
        if (rdy_cnt - r0 !== BLK) begin
            n_bad++; $display("FAIL restart_pulses: got %0d want %0d", rdy_cnt - r0, BLK);
        end
        give_result(10, 16'h0500, 16'h0100);
        n_vec++;
        if (result_valid !== 1'b1) begin
            n_bad++; $display("FAIL restart_rv: got %b want 1", result_valid);
        end
        tick(1);
        n_vec++;
        if (block_count !== 16'd1 || g0_mag !== 16'h0500) begin
            n_bad++; $display("FAIL restart_bc: got bc %0d g0 %h want 1 / 0500", block_count, g0_mag);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_long_strobes();
        test_hysteresis();
        test_timeout();
        test_overrun_abort();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/magdetect_scheduler.md
MAGDETECT_SCHEDULER -- requirements
Module: magdetect_scheduler

Interface
REQ-001 SHALL have parameter BLOCK_LEN, default 512, samples per Goertzel block.
REQ-002 SHALL have parameter ARM_CYCLES, default 8, cycles dsp_ce is high before sample forwarding begins.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum wait for dsp_g_ready after a block.
REQ-004 SHALL have parameter THRESH, default 16'h0400, detection threshold.
REQ-005 SHALL have parameter HYST_COUNT, default 3, consecutive blocks for a detect change (hysteresis build only).
REQ-006 SHALL have port sys_clk, input, 1, the single clock.
REQ-007 SHALL have port sys_rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports enable (input, 1, run request); adc_sample_valid (input, 1, ADC strobe, may last more than one cycle); adc_sample (input, 8, ADC data).
REQ-009 SHALL have ports dsp_ce (output, 1); dsp_data_rdy (output, 1); dsp_data (output, 8). These drive the Goertzel core.
REQ-010 SHALL have ports dsp_g_ready (input, 1); dsp_g0 (input, 16); dsp_g1 (input, 16). These come from the Goertzel core.
REQ-011 SHALL have outputs g0_mag (16), g1_mag (16), result_valid (1), detect (2), block_count (16), overrun (1) and timeout_err (1).

Function
REQ-012 SHALL implement states IDLE, ARM, STREAM, WAIT_RESULT, REPORT and RECOVER.
REQ-013 IDLE: dsp_ce=0; enable=1 -> ARM.
REQ-014 ARM: dsp_ce=1; after ARM_CYCLES cycles -> STREAM; strobes in ARM are discarded silently.
REQ-015 SHALL accept one sample per rising edge of adc_sample_valid, regardless of strobe length.
REQ-016 STREAM: each accepted sample SHALL produce a one-cycle dsp_data_rdy pulse, with dsp_data holding that sample, one cycle after the edge.
REQ-017 STREAM: the BLOCK_LEN-th forwarded sample -> WAIT_RESULT in the same cycle its dsp_data_rdy pulse is issued; the sample counter then resets to 0.
REQ-018 WAIT_RESULT: dsp_ce stays 1; a strobe edge sets sticky overrun and is not forwarded.
REQ-019 WAIT_RESULT: dsp_g_ready=1 captures dsp_g0 into g0_mag and dsp_g1 into g1_mag -> REPORT.
REQ-020 WAIT_RESULT: TIMEOUT_CYCLES without dsp_g_ready sets sticky timeout_err -> RECOVER; if dsp_g_ready and timeout coincide, dsp_g_ready wins.
REQ-021 RECOVER: dsp_ce=0 for exactly one cycle -> ARM if enable=1, else IDLE.
REQ-022 REPORT: one cycle, result_valid=1, block_count increments (wraps 16'hFFFF->0) -> STREAM if enable=1, else IDLE; dsp_ce is not re-armed.
REQ-023 The detect raw value SHALL be bit0=(g0_mag>=THRESH) and bit1=(g1_mag>=THRESH), using unsigned 16-bit compares evaluated in REPORT.
REQ-024 enable=0 in any state except REPORT SHALL -> IDLE next cycle, discarding the partial block, with no result_valid.
REQ-025 overrun and timeout_err SHALL clear only on reset or on the IDLE->ARM transition.

Reset
REQ-026 sys_rst=1 SHALL force IDLE, clear all counters, and drive every output to 0, including g0_mag, g1_mag, detect and block_count.
REQ-027 Reset SHALL take priority over all other events, including mid-block and mid-REPORT.

Configuration
REQ-028 SHALL define macro MAGDETECT_HYST_EN.
REQ-029 With MAGDETECT_HYST_EN defined, each detect bit SHALL change only after HYST_COUNT consecutive REPORTs disagreeing with its current value; each bit has its own counter, and any agreeing REPORT resets that counter.
REQ-030 With MAGDETECT_HYST_EN undefined, detect SHALL take the raw value at every REPORT, and the HYST_COUNT logic SHALL be absent.

Structure
REQ-031 Package magdetect_pkg SHALL hold the state enumeration and the default values for BLOCK_LEN, ARM_CYCLES, TIMEOUT_CYCLES and THRESH.
REQ-032 The single sub-module SHALL be rise_detect, a registered rising-edge detector for adc_sample_valid.

Verification
REQ-033 The bench SHALL cover normal operation: enable, 512 strobes at 2 us, dsp_g_ready after 100 cycles with G0=0x0500, G1=0x0100 -> result_valid one cycle, detect=2'b01, block_count=1.
REQ-034 The bench SHALL cover long strobes: 3-cycle strobes -> exactly one dsp_data_rdy per strobe, with 512 pulses per block.
REQ-035 The bench SHALL cover timeout: dsp_g_ready never asserted -> timeout_err=1 after 4096 cycles, one cycle dsp_ce=0, then ARM.
REQ-036 The bench SHALL cover overrun and abort: a strobe during WAIT_RESULT -> overrun=1, with no dsp_data_rdy; enable=0 at sample 200 -> IDLE, with no result_valid.
REQ-037 The bench SHALL cover hysteresis: with MAGDETECT_HYST_EN, G0 above THRESH for 2 blocks -> detect[0]=0, and for a 3rd block -> detect[0]=1; without the macro, detect[0]=1 after the first block.
REQ-038 The bench SHALL cover reset mid-STREAM: sys_rst at sample 300 -> all outputs 0 next cycle; a restart yields a full 512-sample block.
